mips_cpu_bus_bridge: RTL and testbench
======================================

Name: mips_cpu_bus_bridge

Overview:
Sits directly downstream of the Harvard CPU's instruction and data ports. It merges both onto a single Avalon-style memory master with waitrequest and drives the CPU's clk_enable, so the core only advances once every access it needs has completed. Instruction fetches are cached by address, so repeated steps at the same PC cost no bus cycles. This allows the unmodified Harvard core to run against shared, slow memory.

Parameters:
MAX_WAIT, 0, max cycles a transaction may see waitrequest high before it is aborted; 0 disables the timeout.

Ports:
clk  input  1  clock; all state changes on its rising edge.
reset  input  1  asynchronous, active-low reset.
instr_address  input  32  CPU fetch address.
instr_readdata  output  32  registered instruction word for the CPU.
data_address  input  32  CPU data address.
data_read  input  1  CPU data read request.
data_write  input  1  CPU data write request; has priority if both are high.
data_writedata  input  32  CPU store data.
data_readdata  output  32  registered load data for the CPU.
cpu_clk_enable  output  1  one-cycle pulse that steps the CPU.
bus_address  output  32  memory address.
bus_read  output  1  memory read strobe.
bus_write  output  1  memory write strobe.
bus_writedata  output  32  memory write data.
bus_byteenable  output  4  always 4'b1111.
bus_readdata  input  32  valid in the cycle waitrequest is low.
bus_waitrequest  input  1  memory stall.
bus_error  output  1  sticky timeout flag.

Behaviour:
- Reset (reset low, asynchronous): state IDLE; all outputs 0 except bus_byteenable=4'b1111; instr_valid=0; wait counter 0. bus_read and bus_write drop immediately, aborting any in-flight transaction.
- State IDLE:
  - If !instr_valid or instr_tag != instr_address: go IFETCH.
  - Else if data_read|data_write: go DACCESS.
  - Else: go RELEASE.
- State IFETCH: drive bus_read=1, bus_address=instr_address.
  - On the first cycle with waitrequest=0: capture bus_readdata into instr_readdata; set instr_tag=instr_address and instr_valid=1.
  - Then go DACCESS if a data request is pending, else RELEASE.
- State DACCESS: drive bus_address=data_address.
  - Write (data_write=1): bus_write=1, bus_writedata=data_writedata.
  - Read: bus_read=1; on waitrequest=0 capture bus_readdata into data_readdata.
  - Go RELEASE on completion.
- State RELEASE: cpu_clk_enable=1 for exactly this cycle; go IDLE.
- Strobes: bus_read and bus_write are never high together, and are high only in IFETCH/DACCESS. Address and data are held stable while waitrequest=1.
- Ordering: instruction access always precedes data access within a step.
- Latency per CPU step (zero-wait memory):
  - 2 cycles with no access (IDLE, RELEASE).
  - 3 cycles with instruction miss only, or data access only.
  - 4 cycles with both.
  - Each waitrequest cycle adds 1.
- Data requests are re-serviced on every step in which data_read/data_write are high. A store held across two CPU steps is written twice; this is accepted because the repeat is idempotent.
- Timeout (MAX_WAIT>0): the wait counter increments each cycle waitrequest=1 and clears on completion. When it reaches MAX_WAIT:
  - Deassert the strobe and set bus_error=1 (sticky until reset).
  - Load 32'h00000000 into the readdata register for the aborted access.
  - A timed-out fetch leaves instr_valid=0.
  - Proceed as if the access completed.
- Store hazard on instruction cache: a write whose data_address equals instr_tag clears instr_valid.
- data_readdata and instr_readdata hold their values between captures.

Decomposition:
- Shared package mips_cpu_bus_pkg: bridge_state_t enum (IDLE, IFETCH, DACCESS, RELEASE) and constant BYTEENABLE_ALL=4'b1111.
- One sub-module is natural: mips_cpu_bus_timeout, the wait counter plus abort/bus_error logic, parameterised by MAX_WAIT.

Test Plan:
- Reset asserted mid-DACCESS with waitrequest=1 -> bus_read/bus_write go to 0 before the next clk edge; after release, state is IDLE, cpu_clk_enable=0, outputs 0.
- instr_address=32'hBFC00000, memory returns 32'h24020005, waitrequest=0, no data request -> exactly one bus_read at BFC00000; cpu_clk_enable pulses on the 3rd cycle; instr_readdata=32'h24020005.
- Same instr_address on the next step -> no bus strobe; enable pulses after 2 cycles.
- Cached fetch, data_read=1, data_address=32'h00001000, waitrequest high 3 cycles then low with 32'hDEADBEEF -> data_readdata=32'hDEADBEEF; enable pulses 6 cycles after the step starts.
- data_write=1, data_address equal to the cached instr_address, data_writedata=32'h12345678 -> one bus_write with those values and byteenable=4'hF; the next step re-fetches the instruction.
- MAX_WAIT=4, waitrequest stuck high on a data read -> strobe drops after 4 wait cycles; bus_error=1; data_readdata=0; enable still pulses; bus_error stays 1 on later clean accesses.

Source files
------------

// File: rtl/mips_cpu_bus_pkg.sv
// Shared types and constants for the Harvard-to-Avalon CPU bus bridge.
package mips_cpu_bus_pkg;

  // Bridge sequencer states; one CPU step walks IDLE -> [IFETCH] -> [DACCESS] -> RELEASE.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IFETCH  = 2'd1,
    DACCESS = 2'd2,
    RELEASE = 2'd3
  } bridge_state_t;

  // The bridge only ever issues full-word transfers.
  localparam logic [3:0] BYTEENABLE_ALL = 4'b1111;

endpackage

// File: rtl/mips_cpu_bus_timeout.sv
// Waitrequest watchdog: counts stalled cycles of the current transfer and
// aborts it once MAX_WAIT stalled cycles have been seen. MAX_WAIT=0 disables it.
module mips_cpu_bus_timeout #(
  parameter int MAX_WAIT = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic active,
  input  logic waitrequest,
  output logic abort,
  output logic bus_error
);

  localparam int CW   = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT);
  localparam int LAST = (MAX_WAIT == 0) ? 0 : MAX_WAIT - 1;

  logic [CW-1:0] wait_cnt;

  // The MAX_WAIT-th stalled cycle is the last one the strobe stays high.
  assign abort = (MAX_WAIT != 0) && active && waitrequest && (wait_cnt == CW'(LAST));

  // Stall counter: advances while the transfer is stalled, clears on completion or idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if ((MAX_WAIT != 0) && active && waitrequest && !abort) begin
      wait_cnt <= wait_cnt + CW'(1);
    end else begin
      wait_cnt <= '0;
    end
  end

  // Sticky error flag; only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_error <= 1'b0;
    end else if (abort) begin
      bus_error <= 1'b1;
    end
  end

endmodule

// File: rtl/mips_cpu_bus_bridge.sv
// Merges the CPU's instruction and data ports onto one Avalon-style master and
// steps the CPU with a one-cycle clk_enable pulse once all its accesses are done.
// The last fetched instruction is cached by address so a stalled PC costs no bus cycles.
module mips_cpu_bus_bridge
  import mips_cpu_bus_pkg::*;
#(
  parameter int MAX_WAIT = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr_address,
  output logic [31:0] instr_readdata,
  input  logic [31:0] data_address,
  input  logic        data_read,
  input  logic        data_write,
  input  logic [31:0] data_writedata,
  output logic [31:0] data_readdata,
  output logic        cpu_clk_enable,
  output logic [31:0] bus_address,
  output logic        bus_read,
  output logic        bus_write,
  output logic [31:0] bus_writedata,
  output logic [3:0]  bus_byteenable,
  input  logic [31:0] bus_readdata,
  input  logic        bus_waitrequest,
  output logic        bus_error
);

  bridge_state_t state, state_next;

  logic [31:0] instr_tag;
  logic        instr_valid;
  logic        data_req;
  logic        instr_hit;
  logic        active;
  logic        abort;
  logic        done;

  assign data_req  = data_read | data_write;
  assign instr_hit = instr_valid && (instr_tag == instr_address);
  assign active    = bus_read | bus_write;
  // A transfer ends either normally or by watchdog abort; both advance the sequencer.
  assign done      = active && (!bus_waitrequest || abort);

  assign bus_byteenable = BYTEENABLE_ALL;

  mips_cpu_bus_timeout #(
    .MAX_WAIT(MAX_WAIT)
  ) u_timeout (
    .clk        (clk),
    .rst_n      (reset),
    .active     (active),
    .waitrequest(bus_waitrequest),
    .abort      (abort),
    .bus_error  (bus_error)
  );

  // State register; async reset returns to IDLE, which drops the strobes at once.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: non-blocking assignment so every flop samples pre-edge values.
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic: fetch on a cache miss first, then the data access, then release.
  always_comb begin
    // NOTE: default first so no path through the case leaves state_next unassigned (no latch).
    state_next = state;
    case (state)
      IDLE: begin
        if (!instr_hit)    state_next = IFETCH;
        else if (data_req) state_next = DACCESS;
        else               state_next = RELEASE;
      end
      IFETCH:  if (done) state_next = data_req ? DACCESS : RELEASE;
      DACCESS: if (done) state_next = RELEASE;
      RELEASE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Bus and CPU-enable outputs decoded purely from state, so they hold steady under waitrequest.
  always_comb begin
    bus_read       = 1'b0;
    bus_write      = 1'b0;
    bus_address    = '0;
    bus_writedata  = '0;
    cpu_clk_enable = 1'b0;
    case (state)
      IFETCH: begin
        bus_read    = 1'b1;
        bus_address = instr_address;
      end
      DACCESS: begin
        bus_address = data_address;
        if (data_write) begin
          bus_write     = 1'b1;
          bus_writedata = data_writedata;
        end else begin
          bus_read = 1'b1;
        end
      end
      RELEASE: cpu_clk_enable = 1'b1;
      default: ;
    endcase
  end

  // Read-data capture and instruction cache tag; an aborted read loads zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr_readdata <= '0;
      data_readdata  <= '0;
      instr_tag      <= '0;
      instr_valid    <= 1'b0;
    end else begin
      if (state == IFETCH && done) begin
        instr_readdata <= abort ? '0 : bus_readdata;
        instr_tag      <= instr_address;
        instr_valid    <= !abort;
      end
      if (state == DACCESS && done) begin
        if (data_write) begin
          // A store over the cached instruction makes the cached copy stale.
          if (data_address == instr_tag) instr_valid <= 1'b0;
        end else begin
          data_readdata <= abort ? '0 : bus_readdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_mips_cpu_bus_bridge.sv
// Directed, table-driven bench for mips_cpu_bus_bridge (built with MAX_WAIT=4).
// Each table row is one CPU step; a small memory responder inserts wait states.
module tb_mips_cpu_bus_bridge;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] instr_address = '0;
  logic [31:0] instr_readdata;
  logic [31:0] data_address = '0;
  logic        data_read = 1'b0;
  logic        data_write = 1'b0;
  logic [31:0] data_writedata = '0;
  logic [31:0] data_readdata;
  logic        cpu_clk_enable;
  logic [31:0] bus_address;
  logic        bus_read;
  logic        bus_write;
  logic [31:0] bus_writedata;
  logic [3:0]  bus_byteenable;
  logic [31:0] bus_readdata = '0;
  logic        bus_waitrequest = 1'b0;
  logic        bus_error;

  int n_cmp = 0;
  int n_bad = 0;
  bit overlap = 1'b0;

  mips_cpu_bus_bridge #(.MAX_WAIT(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .instr_address  (instr_address),
    .instr_readdata (instr_readdata),
    .data_address   (data_address),
    .data_read      (data_read),
    .data_write     (data_write),
    .data_writedata (data_writedata),
    .data_readdata  (data_readdata),
    .cpu_clk_enable (cpu_clk_enable),
    .bus_address    (bus_address),
    .bus_read       (bus_read),
    .bus_write      (bus_write),
    .bus_writedata  (bus_writedata),
    .bus_byteenable (bus_byteenable),
    .bus_readdata   (bus_readdata),
    .bus_waitrequest(bus_waitrequest),
    .bus_error      (bus_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] iaddr;
    logic [31:0] iword;
    logic        drd;
    logic        dwr;
    logic [31:0] daddr;
    logic [31:0] dword;
    logic [31:0] wdata;
    int          wait_n;       // wait cycles per transfer; 255 = stuck
    int          exp_cycles;   // cycle (1 = IDLE) in which cpu_clk_enable pulses
    int          exp_reads;
    int          exp_writes;
    int          exp_strobes;  // cycles with a strobe high
    logic [31:0] exp_addr;     // address of the last strobed cycle
    logic [31:0] exp_instr;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Runs one CPU step from an IDLE cycle through the release pulse and checks it.
  task automatic run_step(input vec_t v, input int idx);
    int          wleft;
    int          cyc;
    int          reads;
    int          writes;
    int          strobes;
    logic [31:0] saddr;
    logic [31:0] waddr;
    logic [31:0] wdat;
    logic [3:0]  be;
    bit          got;
    instr_address  = v.iaddr;
    data_read      = v.drd;
    data_write     = v.dwr;
    data_address   = v.daddr;
    data_writedata = v.wdata;
    wleft = v.wait_n;
    cyc = 0; reads = 0; writes = 0; strobes = 0; got = 1'b0;
    saddr = '0; waddr = '0; wdat = '0; be = '0;
    for (int c = 1; c <= 40 && !got; c++) begin
      @(negedge clk);
      cyc = c;
      if (bus_read && bus_write) overlap = 1'b1;
      if (bus_read || bus_write) begin
        strobes++;
        saddr = bus_address;
        if (wleft > 0) begin
          bus_waitrequest = 1'b1;
          bus_readdata    = 32'hBAD0BAD0;
          wleft--;
        end else begin
          bus_waitrequest = 1'b0;
          bus_readdata    = (bus_address == v.iaddr) ? v.iword : v.dword;
          if (bus_read) reads++;
          else begin
            writes++;
            waddr = bus_address;
            wdat  = bus_writedata;
            be    = bus_byteenable;
          end
          wleft = v.wait_n;
        end
      end else begin
        bus_waitrequest = 1'b0;
        bus_readdata    = '0;
      end
      if (cpu_clk_enable) got = 1'b1;
    end
    if (!got) cyc = 99;
    check($sformatf("v%0d.cycles", idx), cyc, v.exp_cycles);
    check($sformatf("v%0d.reads", idx), reads, v.exp_reads);
    check($sformatf("v%0d.writes", idx), writes, v.exp_writes);
    check($sformatf("v%0d.strobes", idx), strobes, v.exp_strobes);
    if (v.exp_strobes != 0) check($sformatf("v%0d.addr", idx), saddr, v.exp_addr);
    if (v.exp_writes != 0) begin
      check($sformatf("v%0d.waddr", idx), waddr, v.daddr);
      check($sformatf("v%0d.wdata", idx), wdat, v.wdata);
      check($sformatf("v%0d.byteen", idx), {28'd0, be}, 32'hF);
    end
    check($sformatf("v%0d.instr", idx), instr_readdata, v.exp_instr);
    check($sformatf("v%0d.data", idx), data_readdata, v.exp_data);
    check($sformatf("v%0d.err", idx), {31'd0, bus_error}, {31'd0, v.exp_err});
  endtask

  initial begin
    vec_t post;
    //          iaddr         iword         rd    wr    daddr         dword         wdata        wt  cyc rd wr st  addr          instr         data          err
    vecs[0]  = '{32'hBFC00000, 32'h24020005, 1'b0, 1'b0, 32'h00000000, 32'h0,        32'h0,        0,  3, 1, 0, 1, 32'hBFC00000, 32'h24020005, 32'h00000000, 1'b0};
    vecs[1]  = '{32'hBFC00000, 32'h24020005, 1'b0, 1'b0, 32'h00000000, 32'h0,        32'h0,        0,  2, 0, 0, 0, 32'h0,        32'h24020005, 32'h00000000, 1'b0};
    vecs[2]  = '{32'hBFC00000, 32'h24020005, 1'b1, 1'b0, 32'h00001000, 32'hDEADBEEF, 32'h0,        3,  6, 1, 0, 4, 32'h00001000, 32'h24020005, 32'hDEADBEEF, 1'b0};
    vecs[3]  = '{32'hBFC00000, 32'h24020005, 1'b0, 1'b1, 32'hBFC00000, 32'h0,        32'h12345678, 0,  3, 0, 1, 1, 32'hBFC00000, 32'h24020005, 32'hDEADBEEF, 1'b0};
    vecs[4]  = '{32'hBFC00000, 32'h24020005, 1'b0, 1'b0, 32'h00000000, 32'h0,        32'h0,        0,  3, 1, 0, 1, 32'hBFC00000, 32'h24020005, 32'hDEADBEEF, 1'b0};
    vecs[5]  = '{32'hBFC00004, 32'h8C430000, 1'b1, 1'b0, 32'h00002000, 32'hCAFEF00D, 32'h0,        0,  4, 2, 0, 2, 32'h00002000, 32'h8C430000, 32'hCAFEF00D, 1'b0};
    vecs[6]  = '{32'hBFC00004, 32'h8C430000, 1'b1, 1'b1, 32'h00003000, 32'h0,        32'hA5A5A5A5, 0,  3, 0, 1, 1, 32'h00003000, 32'h8C430000, 32'hCAFEF00D, 1'b0};
    vecs[7]  = '{32'hBFC00004, 32'h8C430000, 1'b0, 1'b0, 32'h00000000, 32'h0,        32'h0,        0,  2, 0, 0, 0, 32'h0,        32'h8C430000, 32'hCAFEF00D, 1'b0};
    vecs[8]  = '{32'hBFC00004, 32'h8C430000, 1'b1, 1'b0, 32'h00004000, 32'h77777777, 32'h0,      255,  6, 0, 0, 4, 32'h00004000, 32'h8C430000, 32'h00000000, 1'b1};
    vecs[9]  = '{32'hBFC00004, 32'h8C430000, 1'b1, 1'b0, 32'h00001000, 32'h11112222, 32'h0,        1,  4, 1, 0, 2, 32'h00001000, 32'h8C430000, 32'h11112222, 1'b1};
    vecs[10] = '{32'hBFC00008, 32'h00000020, 1'b0, 1'b0, 32'h00000000, 32'h0,        32'h0,      255,  6, 0, 0, 4, 32'hBFC00008, 32'h00000000, 32'h11112222, 1'b1};
    vecs[11] = '{32'hBFC00008, 32'h00000020, 1'b0, 1'b0, 32'h00000000, 32'h0,        32'h0,        0,  3, 1, 0, 1, 32'hBFC00008, 32'h00000020, 32'h11112222, 1'b1};
    vecs[12] = '{32'hBFC00008, 32'h00000020, 1'b0, 1'b0, 32'h00000000, 32'h0,        32'h0,        0,  2, 0, 0, 0, 32'h0,        32'h00000020, 32'h11112222, 1'b1};

    // Reset state.
    #12;
    check("rst.bus_read", {31'd0, bus_read}, 32'd0);
    check("rst.bus_write", {31'd0, bus_write}, 32'd0);
    check("rst.enable", {31'd0, cpu_clk_enable}, 32'd0);
    check("rst.byteen", {28'd0, bus_byteenable}, 32'hF);
    check("rst.err", {31'd0, bus_error}, 32'd0);
    check("rst.instr", instr_readdata, 32'd0);
    check("rst.data", data_readdata, 32'd0);
    check("rst.addr", bus_address, 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;

    for (int i = 0; i < 13; i++) run_step(vecs[i], i);

    // Async reset in the middle of a stalled data read.
    instr_address = 32'hBFC00008;
    data_read     = 1'b1;
    data_write    = 1'b0;
    data_address  = 32'h00005000;
    @(negedge clk);
    @(negedge clk);
    bus_waitrequest = 1'b1;
    check("mid.bus_read", {31'd0, bus_read}, 32'd1);
    #2 reset = 1'b0;
    #1;
    check("mid.bus_read_drop", {31'd0, bus_read}, 32'd0);
    check("mid.bus_write_drop", {31'd0, bus_write}, 32'd0);
    check("mid.enable", {31'd0, cpu_clk_enable}, 32'd0);
    check("mid.err_clr", {31'd0, bus_error}, 32'd0);
    check("mid.instr", instr_readdata, 32'd0);
    check("mid.data", data_readdata, 32'd0);
    check("mid.addr", bus_address, 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    bus_waitrequest = 1'b0;
    check("post.enable", {31'd0, cpu_clk_enable}, 32'd0);
    check("post.bus_read", {31'd0, bus_read}, 32'd0);

    // Cache was invalidated by reset: the same PC must be fetched again.
    post = '{32'hBFC00008, 32'h00000020, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 0, 3, 1, 0, 1,
             32'hBFC00008, 32'h00000020, 32'h00000000, 1'b0};
    run_step(post, 13);

    check("no_overlap", {31'd0, overlap}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
